// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich state-update slice: word geometry,
// default neuron constants, FSM state type and the sign-magnitude compare.
package izh_pkg;

   localparam int unsigned N_DEF = 32;
   localparam int unsigned Q_DEF = 16;

   localparam logic [31:0] V_TH_DEF    = 32'h001E0000;   // +30.0
   localparam logic [31:0] C_RESET_DEF = 32'h80410000;   // -65.0
   localparam logic [31:0] D_INC_DEF   = 32'h00080000;   // +8.0
   localparam logic [31:0] V_INIT_DEF  = 32'h80410000;   // -65.0
   localparam logic [31:0] W_INIT_DEF  = 32'h00000000;   // 0.0

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUM  = 2'd1,
      FIRE = 2'd2,
      OUT  = 2'd3
   } izh_state_e;

   // Signed a >= b on sign-magnitude operands; magnitudes are passed
   // zero-extended so one function serves any word width. -0 equals +0.
   function automatic logic sm_ge(input logic        sa,
                                  input logic        sb,
                                  input logic [62:0] ma,
                                  input logic [62:0] mb);
      logic na;
      logic nb;
      na = sa & (ma != '0);
      nb = sb & (mb != '0);
      if (na != nb) begin
         return ~na;
      end else if (!na) begin
         return ma >= mb;
      end else begin
         return ma <= mb;
      end
   endfunction

endpackage

// File: rtl/izh_state_update_if.sv
// Step handshake bundle between the derivative blocks, the state-update
// block and its downstream consumer.
interface izh_state_update_if #(
   parameter int unsigned N = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dv;
   logic [N-1:0] dw;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] v;
   logic [N-1:0] w;
   logic         spike;

   modport master (
      output in_valid, dv, dw, out_ready,
      input  in_ready, out_valid, v, w, spike
   );

   modport slave (
      input  in_valid, dv, dw, out_ready,
      output in_ready, out_valid, v, w, spike
   );
endinterface

// File: rtl/sm_sat_add.sv
// Combinational sign-magnitude adder with magnitude saturation.
// Overflow clamps the magnitude to all ones keeping the sign; a zero
// result is always +0.
module sm_sat_add #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   localparam int unsigned M = N - 1;

   logic [M-1:0] ma;
   logic [M-1:0] mb;
   logic [M:0]   sum_ext;
   logic [M-1:0] mag;
   logic         sgn;

   assign ma      = a[M-1:0];
   assign mb      = b[M-1:0];
   assign sum_ext = {1'b0, ma} + {1'b0, mb};

   // Select add or subtract by sign agreement, saturate, then normalise zero.
   always_comb begin
      mag = '0;
      sgn = 1'b0;
      if (a[M] == b[M]) begin
         sgn = a[M];
         mag = sum_ext[M] ? '1 : sum_ext[M-1:0];
      end else if (ma >= mb) begin
         sgn = a[M];
         mag = ma - mb;
      end else begin
         sgn = b[M];
         mag = mb - ma;
      end
      if (mag == '0) begin
         sgn = 1'b0;
      end
   end

   assign y = {sgn, mag};

endmodule

// File: rtl/izh_state_update.sv
// Izhikevich state integrator: accepts one (dv, dw) step, integrates v and w
// with saturating sign-magnitude adds, applies the spike reset and holds the
// updated state until the consumer takes it.
// Optional build macro IZH_REFRACTORY_EN adds a refractory counter that
// freezes v for REFRAC steps after each spike.
module izh_state_update
   import izh_pkg::*;
#(
   parameter int unsigned N       = N_DEF,
   parameter int unsigned Q       = Q_DEF,
   parameter logic [N-1:0] V_TH    = V_TH_DEF,
   parameter logic [N-1:0] C_RESET = C_RESET_DEF,
   parameter logic [N-1:0] D_INC   = D_INC_DEF,
   parameter logic [N-1:0] V_INIT  = V_INIT_DEF,
   parameter logic [N-1:0] W_INIT  = W_INIT_DEF,
   parameter int           REFRAC  = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   izh_state_update_if.slave  bus
);

   if ((Q >= N) || (N < 2) || (N > 64) || (REFRAC < 0)) begin : g_param_check
      $error("izh_state_update: invalid parameter set");
   end

   izh_state_e   state;
   izh_state_e   state_n;

   logic [N-1:0] dv_q;
   logic [N-1:0] dw_q;
   logic [N-1:0] v_sum;
   logic [N-1:0] w_sum;
   logic [N-1:0] v_r;
   logic [N-1:0] w_r;
   logic         spike_r;

   logic [N-1:0] v_add;
   logic [N-1:0] w_add;
   logic [N-1:0] w_inc;

   logic         accept;
   logic         in_ready_c;
   logic         out_valid_c;
   logic         fire_hit;
   logic         refrac_act;

   sm_sat_add #(.N(N)) u_add_v (.a(v_r),   .b(dv_q),  .y(v_add));
   sm_sat_add #(.N(N)) u_add_w (.a(w_r),   .b(dw_q),  .y(w_add));
   sm_sat_add #(.N(N)) u_add_d (.a(w_sum), .b(D_INC), .y(w_inc));

   assign fire_hit = sm_ge(v_sum[N-1], V_TH[N-1],
                           63'(v_sum[N-2:0]), 63'(V_TH[N-2:0]));

`ifdef IZH_REFRACTORY_EN
   localparam int unsigned RW = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

   logic [RW-1:0] refrac_cnt;

   assign refrac_act = (refrac_cnt != '0);

   // Refractory counter: loaded on a spike, counts down once per frozen step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refrac_cnt <= '0;
      end else if (state == FIRE) begin
         if (refrac_act) begin
            refrac_cnt <= refrac_cnt - 1'b1;
         end else if (fire_hit) begin
            refrac_cnt <= RW'(REFRAC);
         end
      end
   end
`else
   assign refrac_act = 1'b0;
`endif

   assign accept = bus.in_valid && in_ready_c;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_n     = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               state_n = SUM;
            end
         end
         SUM:  state_n = FIRE;
         FIRE: state_n = OUT;
         OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Datapath: latch step, register sums, then commit integrate or spike reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dv_q    <= '0;
         dw_q    <= '0;
         v_sum   <= '0;
         w_sum   <= '0;
         v_r     <= V_INIT;
         w_r     <= W_INIT;
         spike_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dv_q <= bus.dv;
                  dw_q <= bus.dw;
               end
            end
            SUM: begin
               v_sum <= v_add;
               w_sum <= w_add;
            end
            FIRE: begin
               if (refrac_act) begin
                  w_r     <= w_sum;
                  spike_r <= 1'b0;
               end else if (fire_hit) begin
                  v_r     <= C_RESET;
                  w_r     <= w_inc;
                  spike_r <= 1'b1;
               end else begin
                  v_r     <= v_sum;
                  w_r     <= w_sum;
                  spike_r <= 1'b0;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  spike_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.v         = v_r;
   assign bus.w         = w_r;
   assign bus.spike     = spike_r;

endmodule

// File: tb/tb_izh_state_update.sv
// Self-checking bench for izh_state_update: directed cases plus randomized
// steps compared against an integer-arithmetic reference model.
module tb_izh_state_update;
   import izh_pkg::*;

   localparam logic [31:0] VTH  = 32'h001E0000;
   localparam logic [31:0] CR   = 32'h80410000;
   localparam logic [31:0] DI   = 32'h00080000;
   localparam logic [31:0] VI   = 32'h80410000;
   localparam logic [31:0] WI   = 32'h00000000;
   localparam longint      MAXM = 64'h7FFFFFFF;
   localparam int          REFRAC_N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   izh_state_update_if #(.N(32)) bm ();
   izh_state_update_if #(.N(32)) b29 ();
   izh_state_update_if #(.N(32)) bsat ();

   izh_state_update #(.N(32)) u_main (.clk(clk), .rst_n(rst_n), .bus(bm));
   izh_state_update #(.N(32), .V_INIT(32'h001D0000)) u_29 (.clk(clk), .rst_n(rst_n), .bus(b29));
   izh_state_update #(.N(32), .V_INIT(32'h7FFF0000)) u_sat (.clk(clk), .rst_n(rst_n), .bus(bsat));

   // ---------------- reference model (real-valued view of the words) -------
   logic [31:0] mv;
   logic [31:0] mw;
   int          mcnt;

   function automatic longint to_i(input logic [31:0] x);
      longint m;
      m = 0;
      m[30:0] = x[30:0];
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] from_i(input longint val);
      longint      m;
      logic [31:0] r;
      m = (val < 0) ? -val : val;
      if (m > MAXM) m = MAXM;
      r = 32'(m);
      if (val < 0 && m != 0) r[31] = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] sadd(input logic [31:0] a, input logic [31:0] b);
      return from_i(to_i(a) + to_i(b));
   endfunction

   task automatic model_reset();
      mv = VI;
      mw = WI;
      mcnt = 0;
   endtask

   task automatic model_step(input logic [31:0] d_v, input logic [31:0] d_w,
                             output logic [31:0] ev, output logic [31:0] ew,
                             output logic es);
      logic [31:0] vs;
      logic [31:0] ws;
      vs = sadd(mv, d_v);
      ws = sadd(mw, d_w);
      if (mcnt > 0) begin
         mw = ws;
         mcnt--;
         es = 1'b0;
      end else if (to_i(vs) >= to_i(VTH)) begin
         mv = CR;
         mw = sadd(ws, DI);
         es = 1'b1;
`ifdef IZH_REFRACTORY_EN
         mcnt = REFRAC_N;
`endif
      end else begin
         mv = vs;
         mw = ws;
         es = 1'b0;
      end
      ev = mv;
      ew = mw;
   endtask

   // One full step on the main instance; lat = -1 when out_valid never came.
   task automatic do_step(input logic [31:0] d_v, input logic [31:0] d_w,
                          input int rdelay,
                          output logic [31:0] ov, output logic [31:0] ow,
                          output logic os, output int lat);
      int n;
      bm.dv = d_v;
      bm.dw = d_w;
      bm.in_valid = 1'b1;
      @(posedge clk); #1;
      bm.in_valid = 1'b0;
      bm.dv = $urandom;
      bm.dw = $urandom;
      n = 1;
      while (!bm.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      lat = bm.out_valid ? n : -1;
      ov = bm.v;
      ow = bm.w;
      os = bm.spike;
      repeat (rdelay) begin
         @(posedge clk); #1;
      end
      bm.out_ready = 1'b1;
      @(posedge clk); #1;
      bm.out_ready = 1'b0;
   endtask

   // ---------------- tests -------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bm.v !== VI) begin bad++; $display("FAIL reset_v got=%h want=%h", bm.v, VI); end
      total++; if (bm.w !== WI) begin bad++; $display("FAIL reset_w got=%h want=%h", bm.w, WI); end
      total++; if (bm.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bm.in_ready); end
      total++; if (bm.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bm.out_valid); end
      total++; if (bm.spike !== 1'b0) begin bad++; $display("FAIL reset_spike got=%b want=0", bm.spike); end
      total++; if (b29.v !== 32'h001D0000) begin bad++; $display("FAIL reset_v_init29 got=%h want=001d0000", b29.v); end
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
   endtask

   task automatic test_basic_step();
      logic [31:0] ov, ow, ev, ew;
      logic        os, es;
      int          lat;
      do_step(32'h00010000, 32'h80008000, 0, ov, ow, os, lat);
      model_step(32'h00010000, 32'h80008000, ev, ew, es);
      total++; if (lat !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
      total++; if (ov !== 32'h80400000) begin bad++; $display("FAIL basic_v got=%h want=80400000", ov); end
      total++; if (ow !== 32'h80008000) begin bad++; $display("FAIL basic_w got=%h want=80008000", ow); end
      total++; if (os !== 1'b0) begin bad++; $display("FAIL basic_spike got=%b want=0", os); end
   endtask

   task automatic test_zero_result();
      logic [31:0] ov, ow, ev, ew;
      logic        os, es;
      int          lat;
      do_step(32'h00410000, 32'h00000000, 1, ov, ow, os, lat);
      model_step(32'h00410000, 32'h00000000, ev, ew, es);
      total++; if (ov !== 32'h00010000) begin bad++; $display("FAIL zero_pre_v got=%h want=00010000", ov); end
      do_step(32'h80010000, 32'h00008000, 0, ov, ow, os, lat);
      model_step(32'h80010000, 32'h00008000, ev, ew, es);
      total++; if (ov !== 32'h00000000) begin bad++; $display("FAIL zero_v got=%h want=00000000", ov); end
      total++; if (ow !== 32'h00000000) begin bad++; $display("FAIL zero_w got=%h want=00000000", ow); end
   endtask

   task automatic test_threshold();
      int n;
      b29.dv = 32'h00010000;
      b29.dw = 32'h00000000;
      b29.in_valid = 1'b1;
      @(posedge clk); #1;
      b29.in_valid = 1'b0;
      n = 1;
      while (!b29.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      total++; if (n !== 3) begin bad++; $display("FAIL thr_latency got=%0d want=3", n); end
      total++; if (b29.spike !== 1'b1) begin bad++; $display("FAIL thr_spike got=%b want=1", b29.spike); end
      total++; if (b29.v !== CR) begin bad++; $display("FAIL thr_v got=%h want=%h", b29.v, CR); end
      total++; if (b29.w !== 32'h00080000) begin bad++; $display("FAIL thr_w got=%h want=00080000", b29.w); end
      b29.out_ready = 1'b1;
      @(posedge clk); #1;
      b29.out_ready = 1'b0;
      total++; if (b29.spike !== 1'b0) begin bad++; $display("FAIL thr_spike_clear got=%b want=0", b29.spike); end
   endtask

   task automatic test_saturation();
      int          n;
      logic [31:0] ev2;
      for (int k = 0; k < 2; k++) begin
         bsat.dv = (k == 0) ? 32'h7FFF0000 : 32'hFFFF0000;
         bsat.dw = 32'h00000000;
         bsat.in_valid = 1'b1;
         @(posedge clk); #1;
         bsat.in_valid = 1'b0;
         n = 1;
         while (!bsat.out_valid && n < 20) begin @(posedge clk); #1; n++; end
         if (k == 0) begin
            total++; if (bsat.out_valid !== 1'b1) begin bad++; $display("FAIL sat_timeout got=%b want=1", bsat.out_valid); end
            total++; if (bsat.spike !== 1'b1) begin bad++; $display("FAIL sat_spike got=%b want=1", bsat.spike); end
            total++; if (bsat.v !== CR) begin bad++; $display("FAIL sat_v got=%h want=%h", bsat.v, CR); end
         end else begin
`ifdef IZH_REFRACTORY_EN
            ev2 = CR;
`else
            ev2 = 32'hFFFFFFFF;
`endif
            total++; if (bsat.v !== ev2) begin bad++; $display("FAIL sat_neg_v got=%h want=%h", bsat.v, ev2); end
            total++; if (bsat.spike !== 1'b0) begin bad++; $display("FAIL sat_neg_spike got=%b want=0", bsat.spike); end
         end
         bsat.out_ready = 1'b1;
         @(posedge clk); #1;
         bsat.out_ready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ev, ew, cv, cw;
      logic        es, cs;
      int          n;
      model_step(32'h00020000, 32'h00010000, ev, ew, es);
      bm.dv = 32'h00020000;
      bm.dw = 32'h00010000;
      bm.in_valid = 1'b1;
      @(posedge clk); #1;
      bm.in_valid = 1'b0;
      n = 1;
      while (!bm.out_valid && n < 20) begin @(posedge clk); #1; n++; end
      cv = bm.v; cw = bm.w; cs = bm.spike;
      total++; if (cv !== ev) begin bad++; $display("FAIL bp_v got=%h want=%h", cv, ev); end
      total++; if (cw !== ew) begin bad++; $display("FAIL bp_w got=%h want=%h", cw, ew); end
      for (int c = 0; c < 5; c++) begin
         bm.in_valid = c[0];
         bm.dv = $urandom;
         bm.dw = $urandom;
         @(posedge clk); #1;
         total++; if (bm.out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c=%0d got=%b want=1", c, bm.out_valid); end
         total++; if (bm.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, bm.in_ready); end
         total++; if ({bm.v, bm.w, bm.spike} !== {ev, ew, es}) begin
            bad++; $display("FAIL bp_hold_state c=%0d got=%h/%h/%b want=%h/%h/%b", c, bm.v, bm.w, bm.spike, ev, ew, es);
         end
      end
      bm.in_valid = 1'b0;
      bm.out_ready = 1'b1;
      @(posedge clk); #1;
      bm.out_ready = 1'b0;
      total++; if (bm.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b want=0", bm.out_valid); end
      total++; if (bm.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b want=1", bm.in_ready); end
   endtask

   task automatic test_reset_in_fire();
      int seen;
      bm.dv = 32'h00050000;
      bm.dw = 32'h00020000;
      bm.in_valid = 1'b1;
      @(posedge clk); #1;          // now in SUM
      bm.in_valid = 1'b0;
      @(posedge clk); #1;          // now in FIRE
      rst_n = 1'b0;
      #1;
      total++; if (bm.v !== VI) begin bad++; $display("FAIL rstfire_v got=%h want=%h", bm.v, VI); end
      total++; if (bm.w !== WI) begin bad++; $display("FAIL rstfire_w got=%h want=%h", bm.w, WI); end
      total++; if (bm.out_valid !== 1'b0) begin bad++; $display("FAIL rstfire_out_valid got=%b want=0", bm.out_valid); end
      total++; if (bm.in_ready !== 1'b1) begin bad++; $display("FAIL rstfire_in_ready got=%b want=1", bm.in_ready); end
      #1;
      rst_n = 1'b1;
      model_reset();
      seen = 0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (bm.out_valid) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rstfire_discard got=%0d want=0", seen); end
   endtask

   task automatic test_random();
      logic [31:0] ov, ow, ev, ew, d_v, d_w;
      logic        os, es;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 7))
            0:       d_v = 32'h0;
            7:       d_v = $urandom & 32'h7FFFFFFF;
            default: d_v = $urandom_range(0, 40 << 16);
         endcase
         if ($urandom_range(0, 9) >= 6) d_v[31] = 1'b1;
         d_w = $urandom_range(0, 4 << 16);
         d_w[31] = $urandom_range(0, 1) == 1;
         do_step(d_v, d_w, $urandom_range(0, 2), ov, ow, os, lat);
         model_step(d_v, d_w, ev, ew, es);
         total++; if (lat !== 3) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d want=3", i, lat); end
         total++; if (ov !== ev) begin bad++; $display("FAIL rnd_v i=%0d got=%h want=%h", i, ov, ev); end
         total++; if (ow !== ew) begin bad++; $display("FAIL rnd_w i=%0d got=%h want=%h", i, ow, ew); end
         total++; if (os !== es) begin bad++; $display("FAIL rnd_spike i=%0d got=%b want=%b", i, os, es); end
      end
   endtask

`ifdef IZH_REFRACTORY_EN
   task automatic test_refractory();
      logic [31:0] ov, ow, ev, ew;
      logic        os, es;
      int          lat;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         do_step(32'h00FA0000, 32'h00010000, 0, ov, ow, os, lat);
         model_step(32'h00FA0000, 32'h00010000, ev, ew, es);
         if (i == 0 || i == 5) begin
            total++; if (os !== 1'b1) begin bad++; $display("FAIL refr_spike i=%0d got=%b want=1", i, os); end
         end else begin
            total++; if (os !== 1'b0) begin bad++; $display("FAIL refr_nospike i=%0d got=%b want=0", i, os); end
         end
         total++; if (ov !== CR) begin bad++; $display("FAIL refr_v i=%0d got=%h want=%h", i, ov, CR); end
         total++; if (ow !== ew) begin bad++; $display("FAIL refr_w i=%0d got=%h want=%h", i, ow, ew); end
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bm.in_valid = 1'b0;   bm.out_ready = 1'b0;   bm.dv = '0;   bm.dw = '0;
      b29.in_valid = 1'b0;  b29.out_ready = 1'b0;  b29.dv = '0;  b29.dw = '0;
      bsat.in_valid = 1'b0; bsat.out_ready = 1'b0; bsat.dv = '0; bsat.dw = '0;
      model_reset();
      test_reset();
      test_basic_step();
      test_zero_result();
      test_threshold();
      test_saturation();
      test_backpressure();
      test_reset_in_fire();
      test_random();
`ifdef IZH_REFRACTORY_EN
      test_refractory();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/izh_state_update.md
Name: izh_state_update

Overview:
- Sequential consumer of the per-step Izhikevich derivatives (dv, dw) produced by the combinational derivative blocks.
- Integrates v += dv and w += dw, detects threshold crossing, applies the spike reset (v = c, w = w + d) and presents the updated state.
- The updated state feeds back into the derivative calculators for the next step.
- All values are N-bit sign-magnitude fixed point: MSB is the sign, remaining bits are the magnitude with Q fractional bits (Q16.16 by default).

Parameters:
- N, 32, total word width (sign + magnitude).
- Q, 16, fractional bits.
- V_TH, 32'h001E0000, spike threshold (+30.0).
- C_RESET, 32'h80410000, post-spike v value (-65.0).
- D_INC, 32'h00080000, post-spike w increment (+8.0).
- V_INIT, 32'h80410000, v value after reset (-65.0).
- W_INIT, 32'h00000000, w value after reset (0.0).
- REFRAC, 4, refractory steps; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  dv/dw valid.
- in_ready  out  1  block can accept a step.
- dv  in  N  scaled v derivative (already multiplied by step).
- dw  in  N  scaled w derivative.
- out_valid  out  1  updated state valid.
- out_ready  in  1  downstream accepts the state.
- v  out  N  membrane state, continuously driven from the register.
- w  out  N  recovery state, continuously driven from the register.
- spike  out  1  high with out_valid when this step fired.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values: v=V_INIT, w=W_INIT, spike=0, out_valid=0, in_ready=1, FSM=IDLE.
- FSM states and transitions:
  - IDLE: in_ready=1. The in_valid&&in_ready handshake latches dv/dw and moves to SUM.
  - SUM: registers v_sum = v+dv and w_sum = w+dw, using saturating sign-magnitude adds. Moves to FIRE.
  - FIRE: if v_sum >= V_TH (signed compare), sets v=C_RESET, w=sat(w_sum+D_INC), spike=1. Otherwise sets v=v_sum, w=w_sum, spike=0. Moves to OUT.
  - OUT: out_valid=1. v, w and spike are held stable until out_ready. On the out_ready handshake: out_valid=0, spike=0, return to IDLE.
- Latency: the handshake at cycle 0 gives out_valid at cycle 3. Best-case throughput is one step per 4 cycles.
- in_ready is 0 in SUM, FIRE and OUT. in_valid is ignored there, and dv/dw may change freely.
- out_ready is ignored when out_valid=0. If out_ready is already high on entering OUT, the block returns to IDLE on the next edge, so out_valid is high for one cycle.
- Arithmetic rules:
  - Equal signs: add magnitudes.
  - Different signs: subtract the smaller magnitude from the larger and take the sign of the larger.
  - Magnitude overflow saturates to all-ones magnitude, keeping the sign.
  - A zero result is always +0 (no -0).
  - Comparison treats -0 == +0.
- v == V_TH exactly counts as a spike.
- Saturated v above threshold still spikes and resets normally.
- Reset mid-operation: the state returns immediately to reset values and any in-flight step is discarded.

Optional Feature:
- Macro: IZH_REFRACTORY_EN.
- With the macro:
  - A counter is loaded with REFRAC on each spike.
  - Each later accepted step while the counter is nonzero skips the v integration (v stays C_RESET), still integrates w, and decrements the counter.
  - v_sum may still cross threshold in that case, but no spike is produced.
  - The counter resets to 0.
- Without the macro: no counter; every step integrates v.

Decomposition:
- Shared package izh_pkg holds:
  - the fixed-point width constants;
  - the default constants (V_TH, C_RESET, D_INC);
  - the FSM state enum (IDLE, SUM, FIRE, OUT).
- One sub-module, sm_sat_add: a combinational sign-magnitude saturating adder. It is instantiated for v and for w; the D_INC add reuses the w instance's structure via a second instance.
- A sm_ge compare function also lives in izh_pkg.

Test Plan:
- After reset: v=32'h80410000, w=0, in_ready=1. Step dv=32'h00010000, dw=32'h80008000 → at cycle 3: v=32'h80400000 (-64.0), w=32'h80008000 (-0.5), spike=0.
- V_INIT=32'h001D0000 (29.0), dv=32'h00010000 → v reaches 30.0 (threshold), so spike=1, v=32'h80410000, w=32'h00080000.
- v=32'h7FFF0000, dv=32'h7FFF0000 → saturation to magnitude all-ones, spike=1, v=C_RESET.
- v=32'h00010000, dv=32'h80010000 → v=32'h00000000 (+0, not -0).
- Hold out_ready=0 for 5 cycles in OUT: out_valid, v, w and spike stay stable, and in_ready=0 while in_valid pulses. Release out_ready → IDLE in 1 cycle.
- Assert rst_n=0 during FIRE → v=V_INIT and out_valid=0 immediately. With IZH_REFRACTORY_EN, the 4 steps after a spike keep v=C_RESET with spike=0.
